// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS EX stage: ALU operations, destination select,
// muldiv FSM states and bus widths. Honours EXECUTE_DIV_EN for the DIV/DIVU classes.
package mips_pkg;

    localparam int LEN         = 32;
    localparam int LEN_MEM_BUS = 9;
    localparam int LEN_WB_BUS  = 2;

    typedef enum logic [4:0] {
        OP_ADDU  = 5'd0,
        OP_SUBU  = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_NOR   = 5'd5,
        OP_SLT   = 5'd6,
        OP_SLTU  = 5'd7,
        OP_SLL   = 5'd8,
        OP_SRL   = 5'd9,
        OP_SRA   = 5'd10,
        OP_SLLV  = 5'd11,
        OP_SRLV  = 5'd12,
        OP_SRAV  = 5'd13,
        OP_LUI   = 5'd14,
        OP_MULT  = 5'd16,
        OP_MULTU = 5'd17,
        OP_DIV   = 5'd18,
        OP_DIVU  = 5'd19,
        OP_MFHI  = 5'd20,
        OP_MFLO  = 5'd21,
        OP_MTHI  = 5'd22,
        OP_MTLO  = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } reg_dst_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Operations that launch an iterative muldiv operation.
    function automatic logic is_md_start(input logic [4:0] op);
`ifdef EXECUTE_DIV_EN
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    // Operations that must wait while the muldiv unit is busy.
    function automatic logic is_md_dep(input logic [4:0] op);
        return is_md_start(op) || (op == OP_MFHI) || (op == OP_MFLO) ||
               (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiplier and (with EXECUTE_DIV_EN) restoring divider
// owning the HI/LO registers.
import mips_pkg::*;

module muldiv_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [4:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [W-1:0] mt_data,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy
);
    localparam int CW = $clog2(W);

    md_state_e       state;
    logic [CW-1:0]   count;
    logic [2*W-1:0]  acc;      // product for MULT; low word is the quotient shifter for DIV
    logic [W-1:0]    opnd;     // multiplicand or divisor magnitude
    logic            negate_q;

    logic            signed_op;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next, mul_res;

`ifdef EXECUTE_DIV_EN
    logic [W-1:0]    rem;
    logic [W-1:0]    dividend;
    logic            negate_r, div_zero, is_div;
    logic [W:0]      r_shift, r_diff;
    logic            r_ge;
    logic [W-1:0]    q_fix, r_fix;
`endif

    assign busy = (state != MD_IDLE);

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        mag_a     = (signed_op && a[W-1]) ? -a : a;
        mag_b     = (signed_op && b[W-1]) ? -b : b;
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        mul_next  = {mul_sum, acc[W-1:1]};
        mul_res   = negate_q ? -acc : acc;
`ifdef EXECUTE_DIV_EN
        r_shift   = {rem, acc[W-1]};
        r_ge      = (r_shift >= {1'b0, opnd});
        r_diff    = r_shift - {1'b0, opnd};
        q_fix     = negate_q ? -acc[W-1:0] : acc[W-1:0];
        r_fix     = negate_r ? -rem : rem;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MD_IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            negate_q <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef EXECUTE_DIV_EN
            rem      <= '0;
            dividend <= '0;
            negate_r <= 1'b0;
            div_zero <= 1'b0;
            is_div   <= 1'b0;
`endif
        end else begin
            case (state)
                MD_IDLE: begin
                    if (hi_we) hi <= mt_data;
                    if (lo_we) lo <= mt_data;
                    if (start) begin
                        state    <= MD_RUN;
                        count    <= CW'(W - 1);
                        acc      <= {{W{1'b0}}, mag_a};
                        opnd     <= mag_b;
                        negate_q <= signed_op && (a[W-1] ^ b[W-1]);
`ifdef EXECUTE_DIV_EN
                        rem      <= '0;
                        dividend <= a;
                        negate_r <= signed_op && a[W-1];
                        div_zero <= (b == '0);
                        is_div   <= (op == OP_DIV) || (op == OP_DIVU);
`endif
                    end
                end
                MD_RUN: begin
`ifdef EXECUTE_DIV_EN
                    if (is_div) begin
                        rem         <= r_ge ? r_diff[W-1:0] : r_shift[W-1:0];
                        acc[W-1:0]  <= {acc[W-2:0], r_ge};
                    end else
`endif
                    acc <= mul_next;
                    count <= count - 1'b1;
                    if (count == '0) state <= MD_DONE;
                end
                MD_DONE: begin
`ifdef EXECUTE_DIV_EN
                    if (is_div) begin
                        lo <= div_zero ? {W{1'b1}} : q_fix;
                        hi <= div_zero ? dividend  : r_fix;
                    end else
`endif
                    begin
                        hi <= mul_res[2*W-1:W];
                        lo <= mul_res[W-1:0];
                    end
                    state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: combinational ALU, branch target, muldiv unit and the EX/MEM
// register. EXECUTE_DIV_EN enables DIV/DIVU; otherwise they pass as NOPs.
import mips_pkg::*;

module execute_stage #(
    parameter int len         = LEN,
    parameter int NB          = $clog2(len),
    parameter int len_mem_bus = LEN_MEM_BUS,
    parameter int len_wb_bus  = LEN_WB_BUS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [len-1:0]         in_pc_next,
    input  logic [len-1:0]         in_data_a,
    input  logic [len-1:0]         in_data_b,
    input  logic [len-1:0]         in_sign_ext,
    input  logic [4:0]             in_shamt,
    input  logic [NB-1:0]          in_rt,
    input  logic [NB-1:0]          in_rd,
    input  logic [4:0]             alu_ctrl,
    input  logic                   alu_src,
    input  logic [1:0]             reg_dst,
    input  logic [len_mem_bus-1:0] in_memory_bus,
    input  logic [len_wb_bus-1:0]  in_writeBack_bus,
    output logic [len-1:0]         out_addr_mem,
    output logic [len-1:0]         out_write_data,
    output logic                   out_zero_flag,
    output logic [len-1:0]         out_pc_branch,
    output logic [len_mem_bus-1:0] out_memory_bus,
    output logic [len_wb_bus-1:0]  out_writeBack_bus,
    output logic [NB-1:0]          out_write_reg,
    output logic                   stall
);
    logic [len-1:0] opb, alu_res, hi, lo;
    logic [NB-1:0]  write_reg;
    logic           busy, md_start, hi_we, lo_we;

    assign stall    = busy && is_md_dep(alu_ctrl);
    assign md_start = is_md_start(alu_ctrl) && !busy;
    assign hi_we    = (alu_ctrl == OP_MTHI) && !stall;
    assign lo_we    = (alu_ctrl == OP_MTLO) && !stall;

    muldiv_unit #(.W(len)) u_muldiv (
        .clk     (clk),
        .reset   (reset),
        .start   (md_start),
        .op      (alu_ctrl),
        .a       (in_data_a),
        .b       (in_data_b),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .mt_data (in_data_a),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy)
    );

    always_comb begin
        opb     = alu_src ? in_sign_ext : in_data_b;
        alu_res = '0;
        case (alu_ctrl)
            OP_ADDU: alu_res = in_data_a + opb;
            OP_SUBU: alu_res = in_data_a - opb;
            OP_AND:  alu_res = in_data_a & opb;
            OP_OR:   alu_res = in_data_a | opb;
            OP_XOR:  alu_res = in_data_a ^ opb;
            OP_NOR:  alu_res = ~(in_data_a | opb);
            OP_SLT:  alu_res = {{(len-1){1'b0}}, $signed(in_data_a) < $signed(opb)};
            OP_SLTU: alu_res = {{(len-1){1'b0}}, in_data_a < opb};
            OP_SLL:  alu_res = opb << in_shamt;
            OP_SRL:  alu_res = opb >> in_shamt;
            OP_SRA:  alu_res = $signed(opb) >>> in_shamt;
            OP_SLLV: alu_res = opb << in_data_a[4:0];
            OP_SRLV: alu_res = opb >> in_data_a[4:0];
            OP_SRAV: alu_res = $signed(opb) >>> in_data_a[4:0];
            OP_LUI:  alu_res = in_sign_ext << 16;
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (reg_dst)
            DST_RD:  write_reg = in_rd;
            DST_RA:  write_reg = NB'(31);
            default: write_reg = in_rt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_addr_mem      <= '0;
            out_write_data    <= '0;
            out_zero_flag     <= 1'b0;
            out_pc_branch     <= '0;
            out_memory_bus    <= '0;
            out_writeBack_bus <= '0;
            out_write_reg     <= '0;
        end else begin
            out_addr_mem   <= alu_res;
            out_write_data <= in_data_b;
            out_zero_flag  <= ((in_data_a - in_data_b) == '0);
            out_pc_branch  <= in_pc_next + (in_sign_ext << 2);
            // A held instruction must not reach MEM/WB twice.
            if (stall) begin
                out_memory_bus    <= '0;
                out_writeBack_bus <= '0;
                out_write_reg     <= '0;
            end else begin
                out_memory_bus    <= in_memory_bus;
                out_writeBack_bus <= in_writeBack_bus;
                out_write_reg     <= write_reg;
            end
        end
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

MIPS EX stage with the ID/EX-to-EX/MEM pipeline register. It computes ALU results, branch targets and the zero flag, and passes the memory and write-back control buses straight through. It holds an iterative multiply/divide unit with HI/LO registers and raises `stall` to the hazard unit while a dependent instruction waits on that unit. Its registered outputs drive the memory stage inputs directly: address, write data, memory bus, write-back bus, write register, zero flag and branch PC.

## Interface
- `len`, 32, datapath width
- `NB`, `$clog2(len)`, register-index width
- `len_mem_bus`, 9, memory-stage control bus width
- `len_wb_bus`, 2, write-back control bus width
- `clk` in 1: clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `in_pc_next` in len: PC+4 of the instruction
- `in_data_a` in len: rs operand
- `in_data_b` in len: rt operand
- `in_sign_ext` in len: sign-extended immediate
- `in_shamt` in 5: shift amount
- `in_rt`, `in_rd` in NB: destination candidates
- `alu_ctrl` in 5: operation code (package encoding)
- `alu_src` in 1: 1 = immediate replaces B
- `reg_dst` in 2: 0 = rt, 1 = rd, 2 = 31
- `in_memory_bus` in len_mem_bus: passthrough
- `in_writeBack_bus` in len_wb_bus: passthrough
- `out_addr_mem` out len: registered ALU result
- `out_write_data` out len: registered `in_data_b`
- `out_zero_flag` out 1: registered (A−B)==0
- `out_pc_branch` out len: registered `in_pc_next + (in_sign_ext<<2)`
- `out_memory_bus`, `out_writeBack_bus`, `out_write_reg` out: registered
- `stall` out 1: combinational; upstream holds ID/EX while high

## Operation
- ALU ops: ADDU, SUBU (wrap, no trap); AND, OR, XOR, NOR; SLT (signed), SLTU; SLL/SRL/SRA by `in_shamt`; SLLV/SRLV/SRAV by A[4:0]; LUI = imm<<16.
- Multiply/divide ops: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- MULT/MULTU: radix-2 shift-add. Signed variant multiplies magnitudes and negates. Result: HI = upper 32 bits, LO = lower 32 bits.
- DIV/DIVU: restoring division. LO = quotient, HI = remainder; remainder takes the sign of the dividend.
- Divide by zero: LO = 0xFFFFFFFF, HI = dividend.
- Signed DIV 0x80000000 / −1: LO = 0x80000000, HI = 0.
- Muldiv FSM states:
  - IDLE→RUN on MULT/DIV issue. Operands are latched and the counter is set to 31.
  - RUN performs one iteration per cycle. At counter 0 it goes to DONE.
  - DONE writes HI/LO, clears busy and returns to IDLE.
- MULT/DIV themselves write no GPR and proceed down the pipe; their forwarded buses must already carry RegWrite=0.
- `stall` = busy AND `alu_ctrl` ∈ {MULT*, DIV*, MF*, MT*}.
- While `stall` is high, the EX/MEM register loads a bubble: `out_memory_bus`=0, `out_writeBack_bus`=0, `out_write_reg`=0. The other outputs may change.
- MTHI/MTLO write HI/LO at the edge when not stalled. MFHI/MFLO place HI/LO on `out_addr_mem`.
- Reset: all outputs 0, HI=LO=0, FSM IDLE, counter 0. A reset mid-operation aborts the operation and leaves HI/LO at 0.

## Timing
- ALU path latency: 1 cycle (inputs at edge t → outputs after edge t+1).
- MULT/DIV issued in cycle t: busy is high during cycles t+1..t+33; HI/LO are written at the edge ending t+33.
- An MFHI present from t+1 stalls through t+33 and is registered at the edge ending t+34 with the new value.
- Back-to-back MULT: the second one stalls until busy=0, then issues.
- `stall` settles combinationally within the cycle and carries no registered delay.

## Configuration
- `EXECUTE_DIV_EN` defined: DIV/DIVU behave as described above.
- Not defined:
  - The restoring-divider datapath is removed.
  - DIV/DIVU act as NOPs: no busy, HI/LO unchanged, bubble-free passthrough.
  - MULT is unaffected.

## Structure
- Package `mips_pkg`:
  - `alu_ctrl` encodings
  - `reg_dst` encodings
  - muldiv FSM state typedef
  - bus widths
- Sub-module `muldiv_unit`: FSM, counter, operand and HI/LO registers, busy. Ports: start, op, a, b, hi, lo, busy, plus MT write.
- The ALU remains combinational inside `execute_stage`.

## Test plan
- ADDU A=0x7FFFFFFF, B=1 → `out_addr_mem`=0x80000000, `out_zero_flag`=0. SUBU A=B=5 → `out_zero_flag`=1. Both appear 1 cycle later.
- Branch with `in_pc_next`=0x100, imm=−2 → `out_pc_branch`=0xF8. Buses pass through unchanged.
- MULT A=−3, B=7, then MFLO on the next cycle → `stall` is high for 33 cycles with bubbles emitted, then `out_addr_mem`=0xFFFFFFEB. MFHI → 0xFFFFFFFF.
- DIV A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=9, B=0 → LO=0xFFFFFFFF, HI=9.
- MULT issued, then `reset` pulsed at cycle 10 → busy=0, `stall`=0, HI=LO=0, all outputs 0 on the next cycle.
- Build without `EXECUTE_DIV_EN`: DIV A=8, B=2 → `stall` never asserts, MFLO returns the prior LO.
